sqrt_fixed_pipe: RTL and testbench

- Parametrised fixed-point square root unit. Successor to the fixed 12-bit/16-frac square root in the raytracer datapath.
- Uses a radix-2 non-restoring digit recurrence and produces one result bit per cycle.
- Generalises the input/output widths and fraction bits, and adds selectable truncate/round-to-nearest, an exactness flag, and valid/ready handshakes on both sides.
- Sits between the normal-vector length computation and the normalisation divider.

---
 rtl/sqrt_fixed_pipe.sv | 181 ++++++++++++++++++
 tb/tb_sqrt_fixed_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_fixed_pipe.sv
// sqrt_fixed_pipe
//   Fixed-point square root using a radix-2 non-restoring digit recurrence.
//   One result bit is produced per clock. The operand A (IN_FRAC fractional
//   bits) is aligned into an RW-bit radicand so that the QW-bit root carries
//   OUT_FRAC fractional bits. Truncation or round-to-nearest is selectable,
//   and the root saturates to all-ones if rounding would overflow.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both high. The source holds valid (and data) until it sees ready; ready
//   may be low at any time and the sink never drops a held result.
//
// Ports
//   clk        clock, rising edge
//   rst_       asynchronous reset, active high
//   in_valid   operand valid
//   in_ready   unit can accept an operand (IDLE only)
//   A          operand, unsigned, IN_FRAC fractional bits
//   out_valid  result valid (HOLD)
//   out_ready  consumer accepts the result
//   Q          result, unsigned, OUT_FRAC fractional bits
//   exact      remainder is zero (root exactly representable)
//   busy       high in CALC and FIN
//   dbg_state  current FSM state (IDLE=0, CALC=1, FIN=2, HOLD=3)
module sqrt_fixed_pipe #(
    parameter int IN_W     = 12,
    parameter int IN_FRAC  = 4,
    parameter int OUT_FRAC = 16,
    parameter int ROUND    = 0,
    localparam int RW_RAW  = IN_W + 2*OUT_FRAC - IN_FRAC,
    localparam int RW      = RW_RAW + (RW_RAW % 2),
    localparam int QW      = RW / 2
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IN_W-1:0] A,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] Q,
    output logic          exact,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    if (2*OUT_FRAC < IN_FRAC) begin : g_bad_params
        $error("sqrt_fixed_pipe: 2*OUT_FRAC must be >= IN_FRAC");
    end

    // Left shift that turns A into R = A * 2^(2*OUT_FRAC - IN_FRAC).
    localparam int SH = 2*OUT_FRAC - IN_FRAC;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;
    localparam int EW = QW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [RW-1:0]        rad;
    logic [QW-1:0]        root;
    logic signed [EW-1:0] rem;
    logic [CW-1:0]        cnt;
    logic                 accept;

    // Recurrence step and final correction
    logic signed [EW-1:0] rem_sh;
    logic signed [EW-1:0] rem_it;
    logic [QW-1:0]        root_it;
    logic signed [EW-1:0] rem_fix;
    logic                 round_up;
    logic [QW-1:0]        q_fin;
    logic                 exact_fin;

    always_comb begin
        // Bring in the next two radicand bits; the top bits of the old
        // remainder are dropped, which is safe because the true remainder
        // always fits in EW signed bits (arithmetic is modulo 2^EW).
        rem_sh = $signed({rem[EW-3:0], rad[RW-1 -: 2]});
        if (!rem[EW-1]) begin
            rem_it = rem_sh - $signed({root, 2'b01});
        end else begin
            rem_it = rem_sh + $signed({root, 2'b11});
        end
        root_it = QW'({root, ~rem_it[EW-1]});

        // Restore a negative final remainder to its true non-negative value.
        if (rem[EW-1]) begin
            rem_fix = rem + $signed({1'b0, root, 1'b1});
        end else begin
            rem_fix = rem;
        end

        // rem > root means sqrt(R) - root > 0.5; ties cannot occur.
        round_up  = (ROUND != 0) && (rem_fix > $signed({2'b00, root}));
        exact_fin = (rem_fix == '0);
        if (round_up) begin
            q_fin = (&root) ? '1 : root + QW'(1);
        end else begin
            q_fin = root;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst_;
                if (in_valid && !rst_) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = FIN;
            end
            FIN: begin
                busy     = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Datapath registers
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            rad   <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            Q     <= '0;
            exact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rad  <= RW'(A) << SH;
                        root <= '0;
                        rem  <= '0;
                        cnt  <= CW'(QW - 1);
                    end
                end
                CALC: begin
                    rad  <= rad << 2;
                    root <= root_it;
                    rem  <= rem_it;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                FIN: begin
                    Q     <= q_fin;
                    exact <= exact_fin;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_fixed_pipe.sv
// tb_sqrt_fixed_pipe
//   Directed bench for sqrt_fixed_pipe. Three instances:
//     dut0 : default widths, truncate
//     dut1 : default widths, round to nearest (same stimulus as dut0)
//     dut2 : IN_W=8, IN_FRAC=0, OUT_FRAC=0, round to nearest (saturation)
//   Expected values are hand-computed constants.
module tb_sqrt_fixed_pipe;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;

    logic        in_valid = 1'b0;
    logic [11:0] a = '0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, exact0, busy0;
    logic [19:0] q0;
    logic [1:0]  st0;
    logic        in_ready1, out_valid1, exact1, busy1;
    logic [19:0] q1;
    logic [1:0]  st1;

    logic        in_valid2 = 1'b0;
    logic [7:0]  a2 = '0;
    logic        out_ready2 = 1'b0;
    logic        in_ready2, out_valid2, exact2, busy2;
    logic [3:0]  q2;
    logic [1:0]  st2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sqrt_fixed_pipe #(.ROUND(0)) dut0 (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready0),
        .A(a), .out_valid(out_valid0), .out_ready(out_ready), .Q(q0),
        .exact(exact0), .busy(busy0), .dbg_state(st0)
    );

    sqrt_fixed_pipe #(.ROUND(1)) dut1 (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready1),
        .A(a), .out_valid(out_valid1), .out_ready(out_ready), .Q(q1),
        .exact(exact1), .busy(busy1), .dbg_state(st1)
    );

    sqrt_fixed_pipe #(.IN_W(8), .IN_FRAC(0), .OUT_FRAC(0), .ROUND(1)) dut2 (
        .clk(clk), .rst_(rst_), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .out_valid(out_valid2), .out_ready(out_ready2), .Q(q2),
        .exact(exact2), .busy(busy2), .dbg_state(st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operand to dut0/dut1 and wait (bounded) for out_valid.
    task automatic issue(input logic [11:0] val, output int lat, output logic busy_ok);
        int n;
        n = 0;
        while (!in_ready0 && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", 32'(in_ready0), 32'd1);
        a = val;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 12'($urandom_range(0, 4095));
        check("in_ready_low_calc", 32'(in_ready0), 32'd0);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid0 && lat < 100) begin
            if (!busy0 || !busy1) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_cleared", 32'(out_valid0), 32'd0);
        check("in_ready_after_release", 32'(in_ready0), 32'd1);
    endtask

    task automatic issue2(input logic [7:0] val, output int lat);
        int n;
        n = 0;
        while (!in_ready2 && n < 50) begin
            tick();
            n++;
        end
        a2 = val;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        logic busy_ok;

        // Reset state
        tick();
        tick();
        check("rst_q0", 32'(q0), 32'h0);
        check("rst_exact0", 32'(exact0), 32'd0);
        check("rst_out_valid0", 32'(out_valid0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_state0", 32'(st0), 32'd0);
        rst_ = 1'b0;
        #1;
        check("rst_in_ready0", 32'(in_ready0), 32'd1);
        tick();

        // 1.0 -> 1.0 exactly, latency 21
        issue(12'h010, lat, busy_ok);
        check("lat_1p0", 32'(lat), 32'd21);
        check("busy_during_1p0", 32'(busy_ok), 32'd1);
        check("busy_hold", 32'(busy0), 32'd0);
        check("q0_1p0", 32'(q0), 32'h10000);
        check("q1_1p0", 32'(q1), 32'h10000);
        check("exact0_1p0", 32'(exact0), 32'd1);
        check("exact1_1p0", 32'(exact1), 32'd1);
        release_result();
        check("q0_retained", 32'(q0), 32'h10000);

        // 2.0 -> 1.41421...
        issue(12'h020, lat, busy_ok);
        check("q0_2p0", 32'(q0), 32'h16A09);
        check("q1_2p0", 32'(q1), 32'h16A0A);
        check("exact0_2p0", 32'(exact0), 32'd0);
        check("exact1_2p0", 32'(exact1), 32'd0);
        release_result();

        // Largest operand
        issue(12'hFFF, lat, busy_ok);
        check("q0_fff", 32'(q0), 32'hFFF7F);
        check("q1_fff", 32'(q1), 32'hFFF80);
        check("exact0_fff", 32'(exact0), 32'd0);
        check("exact1_fff", 32'(exact1), 32'd0);
        release_result();

        // Zero still takes the full latency, then back-to-back 9.0
        issue(12'h000, lat, busy_ok);
        check("lat_zero", 32'(lat), 32'd21);
        check("q0_zero", 32'(q0), 32'h0);
        check("exact0_zero", 32'(exact0), 32'd1);
        release_result();
        issue(12'h090, lat, busy_ok);
        check("q0_9p0", 32'(q0), 32'h30000);
        check("q1_9p0", 32'(q1), 32'h30000);
        check("exact0_9p0", 32'(exact0), 32'd1);
        release_result();

        // Backpressure: 25.0 held for 10 cycles while 4.0 is offered
        issue(12'h190, lat, busy_ok);
        check("q0_25p0", 32'(q0), 32'h50000);
        in_valid = 1'b1;
        a = 12'h040;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid0), 32'd1);
            check("bp_q0", 32'(q0), 32'h50000);
            check("bp_exact0", 32'(exact0), 32'd1);
            check("bp_in_ready", 32'(in_ready0), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", 32'(st0), 32'd0);
        check("bp_release_in_ready", 32'(in_ready0), 32'd1);
        check("bp_release_q0", 32'(q0), 32'h50000);
        issue(12'h040, lat, busy_ok);
        check("lat_after_bp", 32'(lat), 32'd21);
        check("q0_4p0", 32'(q0), 32'h20000);
        check("q1_4p0", 32'(q1), 32'h20000);
        check("exact0_4p0", 32'(exact0), 32'd1);
        release_result();

        // Reset during CALC iteration 7
        a = 12'h020;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_busy", 32'(busy0), 32'd1);
        rst_ = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid0), 32'd0);
        check("midrst_q0", 32'(q0), 32'h0);
        check("midrst_exact0", 32'(exact0), 32'd0);
        check("midrst_busy0", 32'(busy0), 32'd0);
        check("midrst_state0", 32'(st0), 32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        check("postrst_in_ready", 32'(in_ready0), 32'd1);
        issue(12'h090, lat, busy_ok);
        check("lat_postrst", 32'(lat), 32'd21);
        check("q0_postrst", 32'(q0), 32'h30000);
        check("exact0_postrst", 32'(exact0), 32'd1);
        release_result();

        // Narrow instance: 4-bit integer root, rounding and saturation
        issue2(8'd255, lat);
        check("lat2_255", 32'(lat), 32'd5);
        check("q2_255_sat", 32'(q2), 32'hF);
        check("exact2_255", 32'(exact2), 32'd0);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        issue2(8'd3, lat);
        check("q2_3", 32'(q2), 32'h2);
        check("exact2_3", 32'(exact2), 32'd0);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        issue2(8'd16, lat);
        check("q2_16", 32'(q2), 32'h4);
        check("exact2_16", 32'(exact2), 32'd1);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        issue2(8'd240, lat);
        check("q2_240", 32'(q2), 32'hF);
        check("exact2_240", 32'(exact2), 32'd0);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
